instr_fetch_buffer: RTL and testbench
=====================================

// Module: instr_fetch_buffer
// PURPOSE
// - Instruction fetch stage directly upstream of the controller/datapath: drives instruction memory, queues fetched words.
// - Hands the controller one 16-bit word per take and absorbs variable memory latency.
// - A taken branch/jump redirects fetch: the queue is flushed and fetching restarts at the target.
// PARAMETERS
// - ADDR_W    8      instruction address width; PC wraps modulo 2**ADDR_W
// - INSTR_W   16     instruction word width
// - DEPTH     2      prefetch queue entries; power of 2, >= 2
// - RESET_PC  0      fetch address loaded on reset
// PORTS
// - clk          in   1        single clock; all state updates on rising edge
// - reset        in   1        synchronous, active-high
// - mem_req      out  1        read request to instruction memory
// - mem_addr     out  ADDR_W   request address; stable while mem_req=1
// - mem_ack      in   1        memory returns mem_rdata this cycle (same cycle as req allowed)
// - mem_rdata    in   INSTR_W  read data, valid when mem_ack=1
// - instr_valid  out  1        head of queue holds a valid instruction
// - instr        out  INSTR_W  head instruction word
// - instr_pc     out  ADDR_W   address the head word was fetched from
// - instr_take   in   1        controller consumes head this cycle (ignored if instr_valid=0)
// - redirect     in   1        taken branch: flush, restart fetch at redirect_pc
// - redirect_pc  in   ADDR_W   branch target
// BEHAVIOUR
// - Reset: mem_req=0, mem_addr=RESET_PC, instr_valid=0, queue count=0, state=IDLE; fetch_pc=RESET_PC. Reset overrides all inputs.
// - FSM (registered state):
//   IDLE: if count < DEPTH -> assert mem_req at fetch_pc, go REQ; else stay.
//   REQ: mem_req=1, mem_addr=fetch_pc. On mem_ack: push {rdata, fetch_pc}, fetch_pc+=1 (0xFF->0x00 wraps).
//        Then re-request back-to-back if room remains after this push and the same-cycle take; else IDLE.
//   DISCARD: entered on redirect while an unacked request is pending. mem_req and mem_addr hold until mem_ack.
//        Acked data is dropped, not pushed. Then go IDLE, fetching at the latched redirect target.
// - One outstanding request max; mem_addr never changes while mem_req=1 and unacked.
// - Issue rule: request only if count (after this cycle's push/pop) < DEPTH, so an ack never meets a full queue.
// - Take and ack in the same cycle: pop head and push new entry together; count unchanged.
// - Redirect, highest priority after reset: count<=0, instr_valid=0 next cycle, fetch_pc<=redirect_pc.
//   A same-cycle take is ignored. Same-cycle ack data is dropped.
//   Redirect during DISCARD updates the latched target (last one wins).
// - Latency without bypass: mem_ack in cycle N -> instr_valid=1 in cycle N+1.
// - Queue pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
// CONFIGURATION
// - FETCH_BYPASS_EN defined: when queue empty and ack arrives (no redirect), mem_rdata/fetch_pc drive instr/instr_pc combinationally.
//   instr_valid=1 the same cycle. A same-cycle take consumes it without pushing; otherwise it is pushed as normal.
// - FETCH_BYPASS_EN undefined: no combinational path mem_* -> instr_*; 1-cycle latency as above.
// STRUCTURE
// - fetch_pkg: addr_t, instr_t, fetch_state_e {IDLE, REQ, DISCARD}, fetch_entry_t struct {instr_t word; addr_t pc;}.
// - Sub-module fetch_fifo: DEPTH x fetch_entry_t, sync reset, push/pop/flush, count, empty/full.
// - Top: FSM, fetch_pc/redirect target registers, bypass mux.
// TESTING
// - Reset then mem_ack same cycle as each req, rdata=0x1000+addr, no take: reqs at 0x00,0x01, then mem_req=0.
//   count=2, instr=0x1000, instr_pc=0x00.
// - Take every cycle, 3-cycle ack latency: words 0x00..0x05 delivered in order.
//   mem_addr stable through every wait; no duplicates, no gaps.
// - Redirect to 0x40 while req at 0x03 pending: mem_addr stays 0x03 until ack, its data is dropped.
//   Next req is 0x40; first instr_pc after redirect is 0x40.
// - redirect_pc=0xFE, continuous take: delivered PCs 0xFE,0xFF,0x00,0x01 (wrap).
// - Full queue plus take and ack in same cycle: count stays 2, order preserved.
//   Reset asserted mid-REQ: mem_req=0 and instr_valid=0 next cycle, fetch restarts at RESET_PC.
// - FETCH_BYPASS_EN: empty queue, ack with 0xBEEF -> instr=0xBEEF, instr_valid=1 the same cycle.
//   Without the macro, the same stimulus gives instr_valid one cycle later.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction fetch stage.
// Latency: n/a (types, constants and a PC helper only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 8;
    localparam int FETCH_INSTR_W = 16;

    typedef logic [FETCH_ADDR_W-1:0]  addr_t;
    typedef logic [FETCH_INSTR_W-1:0] instr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        instr_t word;
        addr_t  pc;
    } fetch_entry_t;

    // Sequential fetch address; wraps naturally modulo 2**FETCH_ADDR_W.
    function automatic addr_t next_pc(input addr_t pc);
        return pc + addr_t'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry queue of fetched {word, pc} entries with flush.
// Latency: push visible at head the cycle after; head is read combinationally.
// Backpressure: none internally; the producer must not push when full unless popping.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   store [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    // Pointers and occupancy; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Head and status flags.
    always_comb begin
        head  = store[rd_ptr];
        empty = (count == '0);
        full  = (count == CW'(DEPTH));
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: drives instruction memory, queues fetched words, flushes on redirect.
// Latency: mem_ack in cycle N gives instr_valid in N+1 (same cycle when FETCH_BYPASS_EN is defined).
// Backpressure: a request is issued only when the queue will have room, so an ack never meets a full queue.
// Optional feature macro: FETCH_BYPASS_EN (empty-queue ack forwarded combinationally to instr/instr_pc).
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int                      ADDR_W   = FETCH_ADDR_W,
    parameter int                      INSTR_W  = FETCH_INSTR_W,
    parameter int                      DEPTH    = 2,
    parameter logic [FETCH_ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_take,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state;
    fetch_state_e  state_nxt;
    addr_t         fetch_pc;
    addr_t         fetch_pc_nxt;
    addr_t         target_pc;
    addr_t         target_pc_nxt;

    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_after;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;
    logic          ack_live;
    logic          bypass_hit;
    logic          take_ok;
    logic          room;

    fetch_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // An outstanding request is always at fetch_pc; in DISCARD it still names the stale address.
    always_comb begin
        mem_req  = (state != IDLE);
        mem_addr = fetch_pc;
    end

    // Head presentation; the bypass variant forwards an ack straight through when the queue is empty.
`ifdef FETCH_BYPASS_EN
    always_comb begin
        bypass_hit  = fifo_empty & ack_live;
        instr_valid = ~fifo_empty | bypass_hit;
        instr       = fifo_empty ? mem_rdata : head.word;
        instr_pc    = fifo_empty ? fetch_pc  : head.pc;
    end
`else
    always_comb begin
        bypass_hit  = 1'b0;
        instr_valid = ~fifo_empty;
        instr       = head.word;
        instr_pc    = head.pc;
    end
`endif

    // Queue traffic: redirect kills both the take and any same-cycle ack data.
    always_comb begin
        ack_live        = (state == REQ) & mem_ack & ~redirect;
        take_ok         = instr_take & instr_valid & ~redirect;
        push_entry.word = mem_rdata;
        push_entry.pc   = fetch_pc;
        // A bypassed word that is taken in the same cycle never enters the queue.
        fifo_push       = ack_live & ~(bypass_hit & instr_take) & (~fifo_full | fifo_pop);
        fifo_pop        = take_ok & ~fifo_empty;
        if (redirect) begin
            count_after = '0;
        end else begin
            count_after = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
        end
        room = (count_after < CW'(DEPTH));
    end

    // Fetch FSM next-state: one outstanding request, redirect target latched while discarding.
    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        target_pc_nxt = target_pc;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_nxt = redirect_pc;
                end
                if (room) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    if (mem_ack) begin
                        // Request finished this cycle; its data is dropped and the target is fetched next.
                        fetch_pc_nxt = redirect_pc;
                        state_nxt    = REQ;
                    end else begin
                        // mem_addr must hold until the ack, so park the target.
                        target_pc_nxt = redirect_pc;
                        state_nxt     = DISCARD;
                    end
                end else if (mem_ack) begin
                    fetch_pc_nxt = next_pc(fetch_pc);
                    state_nxt    = room ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    target_pc_nxt = redirect_pc;
                end
                if (mem_ack) begin
                    fetch_pc_nxt = redirect ? redirect_pc : target_pc;
                    state_nxt    = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM and address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            target_pc <= RESET_PC;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            target_pc <= target_pc_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: directed scenarios plus randomized traffic against a queue-level model.
// Latency: n/a.
// Backpressure: the bench memory acks after a programmable number of wait cycles.
module tb_instr_fetch_buffer;

    localparam int         DEPTH    = 2;
    localparam logic [7:0] RESET_PC = 8'h00;

    typedef struct {
        logic [15:0] w;
        logic [7:0]  pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_take = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;

    instr_fetch_buffer #(
        .DEPTH       (DEPTH),
        .RESET_PC    (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_take  (instr_take),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the queue the controller should see and the fetch address stream.
    ent_t        mq[$];
    logic [7:0]  next_addr = RESET_PC;
    logic [7:0]  req_addr  = '0;
    bit          outst     = 0;
    bit          drop      = 0;
    logic [7:0]  got_pc[$];
    logic [15:0] got_w[$];
    logic [7:0]  req_log[$];

    // Bench memory.
    bit          resp_busy = 0;
    int          resp_wait = 0;
    int          lat_lo    = 0;
    int          lat_hi    = 0;
    bit          ovr_en    = 0;
    logic [15:0] ovr_val   = '0;

    logic        smp_valid;
    logic [15:0] smp_instr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, compare against the model, advance the model.
    task automatic step(input bit tk, input bit rd, input logic [7:0] rpc, input bit rs);
        bit byp;
        @(negedge clk);
        if (!rs && mem_req && !resp_busy) begin
            resp_busy = 1;
            resp_wait = lat_lo + int'($urandom_range(lat_hi - lat_lo, 0));
        end
        reset       = rs;
        instr_take  = tk;
        redirect    = rd;
        redirect_pc = rpc;
        mem_ack     = !rs && resp_busy && (resp_wait == 0);
        mem_rdata   = mem_ack ? (ovr_en ? ovr_val : 16'h1000 + {8'h00, mem_addr}) : 16'($urandom);
        #1;
        smp_valid = instr_valid;
        smp_instr = instr;
        if (rs) begin
            mq.delete();
            next_addr = RESET_PC;
            outst     = 0;
            drop      = 0;
            resp_busy = 0;
        end else begin
            if (outst) begin
                check("req_hold", mem_req, 1);
                check("addr_hold", mem_addr, req_addr);
            end else if (mem_req) begin
                check("req_addr", mem_addr, next_addr);
                check("issue_room", mq.size() < DEPTH, 1);
                outst    = 1;
                req_addr = mem_addr;
                req_log.push_back(mem_addr);
            end
            byp = 0;
`ifdef FETCH_BYPASS_EN
            byp = mem_ack && !rd && !drop && (mq.size() == 0);
`endif
            check("valid", instr_valid, (mq.size() > 0) || byp);
            if (mq.size() > 0) begin
                check("instr", instr, mq[0].w);
                check("instr_pc", instr_pc, mq[0].pc);
            end else if (byp) begin
                check("byp_instr", instr, mem_rdata);
                check("byp_pc", instr_pc, req_addr);
            end
            check("count", dut.u_fifo.count, mq.size());
            if (rd) begin
                mq.delete();
                next_addr = rpc;
                if (mem_ack) begin
                    outst = 0;
                    drop  = 0;
                end else if (outst) begin
                    drop = 1;
                end
            end else begin
                if (tk && mq.size() > 0) begin
                    got_pc.push_back(mq[0].pc);
                    got_w.push_back(mq[0].w);
                    void'(mq.pop_front());
                end
                if (mem_ack) begin
                    outst = 0;
                    if (drop) begin
                        drop = 0;
                    end else begin
                        next_addr = req_addr + 8'd1;
                        if (byp && tk) begin
                            got_pc.push_back(req_addr);
                            got_w.push_back(mem_rdata);
                        end else begin
                            mq.push_back('{mem_rdata, req_addr});
                        end
                    end
                end
            end
            if (mq.size() > DEPTH) begin
                check("overflow", mq.size(), DEPTH);
            end
            if (mem_ack) begin
                resp_busy = 0;
            end else if (resp_busy) begin
                resp_wait--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        got_pc.delete();
        got_w.delete();
        req_log.delete();
    endtask

    initial begin
        logic [7:0] exp4[4];
        int n;

        // Reset state.
        do_reset();
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, RESET_PC);
        check("rst_valid", instr_valid, 0);
        check("rst_count", dut.u_fifo.count, 0);

        // Zero-latency memory, no take: exactly two requests fill the queue.
        lat_lo = 0; lat_hi = 0;
        repeat (6) step(0, 0, 8'h00, 0);
        check("t1_nreq", req_log.size(), 2);
        if (req_log.size() >= 2) begin
            check("t1_req0", req_log[0], 8'h00);
            check("t1_req1", req_log[1], 8'h01);
        end
        check("t1_req_off", mem_req, 0);
        check("t1_count", dut.u_fifo.count, 2);
        check("t1_valid", instr_valid, 1);
        check("t1_instr", instr, 16'h1000);
        check("t1_pc", instr_pc, 8'h00);

        // Three wait cycles, take every cycle: in-order delivery, no gaps or duplicates.
        do_reset();
        lat_lo = 3; lat_hi = 3;
        n = 0;
        while (got_pc.size() < 6 && n < 200) begin
            step(1, 0, 8'h00, 0);
            n++;
        end
        check("t2_timeout", got_pc.size() >= 6, 1);
        for (int i = 0; i < 6 && i < got_pc.size(); i++) begin
            check("t2_pc", got_pc[i], i);
            check("t2_word", got_w[i], 32'h1000 + i);
        end

        // Redirect while the request at 0x03 is pending.
        do_reset();
        n = 0;
        while (!(mem_req && mem_addr == 8'h03 && !resp_busy) && n < 200) begin
            step(1, 0, 8'h00, 0);
            n++;
        end
        check("t3_reach", mem_addr, 8'h03);
        step(1, 1, 8'h40, 0);
        check("t3_hold_req", mem_req, 1);
        check("t3_hold_addr", mem_addr, 8'h03);
        got_pc.delete(); got_w.delete(); req_log.delete();
        n = 0;
        while (got_pc.size() < 1 && n < 100) begin
            step(1, 0, 8'h00, 0);
            n++;
        end
        check("t3_timeout", got_pc.size() >= 1, 1);
        if (req_log.size() > 0) check("t3_first_req", req_log[0], 8'h40);
        if (got_pc.size() > 0) begin
            check("t3_first_pc", got_pc[0], 8'h40);
            check("t3_first_word", got_w[0], 16'h1040);
        end

        // Redirect near the top of the address space: PC wraps.
        lat_lo = 0; lat_hi = 0;
        step(1, 1, 8'hFE, 0);
        got_pc.delete(); got_w.delete();
        n = 0;
        while (got_pc.size() < 4 && n < 100) begin
            step(1, 0, 8'h00, 0);
            n++;
        end
        check("t4_timeout", got_pc.size() >= 4, 1);
        exp4 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        for (int i = 0; i < 4 && i < got_pc.size(); i++) begin
            check("t4_pc", got_pc[i], exp4[i]);
        end

        // Fill the queue, then take every cycle with back-to-back acks.
        do_reset();
        repeat (5) step(0, 0, 8'h00, 0);
        check("t5_full", dut.u_fifo.count, 2);
        repeat (8) step(1, 0, 8'h00, 0);
        check("t5_n", got_pc.size() >= 6, 1);
        for (int i = 0; i < got_pc.size(); i++) begin
            check("t5_order", got_pc[i], i);
        end

        // Reset in the middle of a pending request.
        do_reset();
        lat_lo = 3; lat_hi = 3;
        repeat (7) step(0, 0, 8'h00, 0);
        check("t6_pre_req", mem_req, 1);
        step(0, 0, 8'h00, 1);
        check("t6_req", mem_req, 0);
        check("t6_valid", instr_valid, 0);
        check("t6_addr", mem_addr, RESET_PC);
        req_log.delete();
        n = 0;
        while (req_log.size() < 1 && n < 20) begin
            step(0, 0, 8'h00, 0);
            n++;
        end
        check("t6_restart", req_log.size(), 1);
        if (req_log.size() > 0) check("t6_restart_pc", req_log[0], RESET_PC);

        // Empty queue, ack carrying 0xBEEF.
        do_reset();
        lat_lo = 0; lat_hi = 0;
        ovr_en = 1; ovr_val = 16'hBEEF;
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
`ifdef FETCH_BYPASS_EN
        check("t7_same_valid", smp_valid, 1);
        check("t7_same_word", smp_instr, 16'hBEEF);
`else
        check("t7_same_valid", smp_valid, 0);
`endif
        step(0, 0, 8'h00, 0);
        check("t7_next_valid", smp_valid, 1);
        check("t7_next_word", smp_instr, 16'hBEEF);
        ovr_en = 0;

        // Randomized traffic: takes, latencies, redirects and occasional resets.
        do_reset();
        lat_lo = 0; lat_hi = 3;
        for (int c = 0; c < 3000; c++) begin
            step(1'($urandom_range(1, 0)),
                 ($urandom_range(19, 0) == 0),
                 8'($urandom),
                 ($urandom_range(299, 0) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
